// File: rtl/fibo_gen_param_if.sv
// rtl/fibo_gen_param_if.sv - control/term interface bundle for the Fibonacci generator
interface fibo_gen_param_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             start;
    logic             clear;
    logic             hold;
    logic [WIDTH-1:0] seed0;
    logic [WIDTH-1:0] seed1;
    logic [CNT_W-1:0] num_terms;
    logic [WIDTH-1:0] term;
    logic             term_valid;
    logic [CNT_W-1:0] term_index;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        output start, clear, hold, seed0, seed1, num_terms,
        input  term, term_valid, term_index, busy, done, overflow
    );

    modport slave (
        input  start, clear, hold, seed0, seed1, num_terms,
        output term, term_valid, term_index, busy, done, overflow
    );
endinterface

// File: rtl/fibo_gen_param.sv
// rtl/fibo_gen_param.sv - seeded Fibonacci term generator with overflow stop
module fibo_gen_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    fibo_gen_param_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a, b;
    logic             a_ok, b_ok;
    logic [CNT_W-1:0] idx, n;
    logic [WIDTH-1:0] term_q;
    logic [CNT_W-1:0] term_index_q;
    logic             term_valid_q;
    logic             done_q;
    logic             overflow_q;

    logic             accept, emit, advance, ovf_set, done_d;
    logic [WIDTH:0]   sum;

    // Carry-out of the extended sum marks the first term that no longer fits.
    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        emit    = 1'b0;
        advance = 1'b0;
        ovf_set = 1'b0;
        done_d  = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        accept  = 1'b1;
                        state_d = (bus.num_terms != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (!bus.hold) begin
                        if (a_ok) begin
                            emit = 1'b1;
                            if (idx == n - CNT_W'(1)) begin
                                state_d = DONE;
                            end else begin
                                advance = 1'b1;
                            end
                        end else begin
                            ovf_set = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            a            <= '0;
            b            <= WIDTH'(1);
            a_ok         <= 1'b1;
            b_ok         <= 1'b1;
            idx          <= '0;
            n            <= '0;
            term_q       <= '0;
            term_index_q <= '0;
            term_valid_q <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            term_valid_q <= emit;
            done_q       <= done_d;
            if (accept) begin
                a          <= bus.seed0;
                b          <= bus.seed1;
                a_ok       <= 1'b1;
                b_ok       <= 1'b1;
                idx        <= '0;
                n          <= bus.num_terms;
                overflow_q <= 1'b0;
            end
            if (emit) begin
                term_q       <= a;
                term_index_q <= idx;
            end
            if (advance) begin
                a    <= b;
                b    <= sum[WIDTH-1:0];
                a_ok <= b_ok;
                b_ok <= a_ok & b_ok & ~sum[WIDTH];
                idx  <= idx + CNT_W'(1);
            end
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.term       = term_q;
    assign bus.term_index = term_index_q;
    assign bus.term_valid = term_valid_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_fibo_gen_param.sv
// tb/tb_fibo_gen_param.sv - self-checking bench for fibo_gen_param
module tb_fibo_gen_param;
    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    fibo_gen_param_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bif ();

    fibo_gen_param #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/term"},       32'(bif.term), 0);
        check({tag, "/term_valid"}, 32'(bif.term_valid), 0);
        check({tag, "/term_index"}, 32'(bif.term_index), 0);
        check({tag, "/busy"},       32'(bif.busy), 0);
        check({tag, "/done"},       32'(bif.done), 0);
        check({tag, "/overflow"},   32'(bif.overflow), 0);
    endtask

    // Reference: the full integer sequence, truncated at the first term that
    // needs more than WIDTH bits; hold cycles just delay the remaining work.
    task automatic run_seq(input string tag, input int s0, input int s1, input int n,
                           input logic [63:0] hold_mask, input bit poke_start);
        longint t[$];
        int     m, emitted, phase, eterm, eidx;
        bit     ov, etv, edone, ebusy, finished, h;
        t = {};
        for (int i = 0; i < n; i++) begin
            if (i == 0)      t.push_back(longint'(s0));
            else if (i == 1) t.push_back(longint'(s1));
            else             t.push_back(t[i-2] + t[i-1]);
        end
        m = n;
        for (int i = 0; i < n; i++) begin
            if (t[i] >= (longint'(1) << WIDTH)) begin
                m = i;
                break;
            end
        end

        bif.seed0     = WIDTH'(s0);
        bif.seed1     = WIDTH'(s1);
        bif.num_terms = CNT_W'(n);
        bif.start     = 1'b1;
        bif.hold      = 1'b0;
        bif.clear     = 1'b0;
        tick();
        bif.start     = 1'b0;
        bif.seed0     = WIDTH'($urandom);
        bif.seed1     = WIDTH'($urandom);
        bif.num_terms = CNT_W'($urandom);
        check({tag, "/acc_busy"},     32'(bif.busy), 1);
        check({tag, "/acc_tv"},       32'(bif.term_valid), 0);
        check({tag, "/acc_done"},     32'(bif.done), 0);
        check({tag, "/acc_overflow"}, 32'(bif.overflow), 0);

        phase    = (n == 0) ? 2 : 1;
        emitted  = 0;
        ov       = 1'b0;
        finished = 1'b0;
        eterm    = 0;
        eidx     = 0;
        for (int c = 1; c <= 200 && !finished; c++) begin
            h          = (c <= 64) ? hold_mask[c-1] : 1'b0;
            bif.hold   = h;
            bif.start  = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            etv   = 1'b0;
            edone = 1'b0;
            ebusy = 1'b1;
            if (phase == 1) begin
                if (!h) begin
                    if (emitted < m) begin
                        etv     = 1'b1;
                        eterm   = int'(t[emitted]);
                        eidx    = emitted;
                        emitted = emitted + 1;
                        if (emitted == n) phase = 2;
                    end else begin
                        ov    = 1'b1;
                        phase = 2;
                    end
                end
            end else begin
                edone = 1'b1;
                ebusy = 1'b0;
                phase = 0;
            end
            check($sformatf("%s/c%0d/tv", tag, c), 32'(bif.term_valid), 32'(etv));
            if (etv) begin
                check($sformatf("%s/c%0d/term", tag, c),  32'(bif.term), 32'(eterm));
                check($sformatf("%s/c%0d/index", tag, c), 32'(bif.term_index), 32'(eidx));
            end
            check($sformatf("%s/c%0d/done", tag, c),     32'(bif.done), 32'(edone));
            check($sformatf("%s/c%0d/busy", tag, c),     32'(bif.busy), 32'(ebusy));
            check($sformatf("%s/c%0d/overflow", tag, c), 32'(bif.overflow), 32'(ov));
            if (phase == 0) finished = 1'b1;
        end
        bif.start = 1'b0;
        bif.hold  = 1'b0;
        check({tag, "/finished"}, 32'(finished), 1);
        tick();
        check({tag, "/after_done"}, 32'(bif.done), 0);
        check({tag, "/after_tv"},   32'(bif.term_valid), 0);
        check({tag, "/ovf_sticky"}, 32'(bif.overflow), 32'(ov));
    endtask

    initial begin
        bit found;
        bif.start     = 1'b0;
        bif.clear     = 1'b0;
        bif.hold      = 1'b0;
        bif.seed0     = '0;
        bif.seed1     = '0;
        bif.num_terms = '0;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_reset_outputs("post_reset_idle");

        run_seq("fib8",       0, 1, 8,  64'h0,  1'b0);
        run_seq("fib12_ovf",  0, 1, 12, 64'h0,  1'b0);
        run_seq("lucas_hold", 2, 1, 5,  64'h38, 1'b0);
        run_seq("zero_terms", 3, 5, 0,  64'h0,  1'b1);
        run_seq("one_term",   9, 7, 1,  64'h0,  1'b1);
        run_seq("seed_ovf",   15, 15, 6, 64'h0, 1'b0);

        // Asynchronous reset in the middle of a run
        bif.seed0 = 4'd0; bif.seed1 = 4'd1; bif.num_terms = 8'd8; bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bif.term_valid && bif.term_index == 8'd3) found = 1'b1;
        end
        check("mid_reset/reached_term3", 32'(found), 1);
        check("mid_reset/term3_value",   32'(bif.term), 2);
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset_async");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("mid_reset/no_done%0d", i), 32'(bif.done), 0);
            check($sformatf("mid_reset/idle%0d", i),    32'(bif.busy), 0);
        end
        run_seq("fib8_restart", 0, 1, 8, 64'h0, 1'b0);

        // Clear mid-run, asserted together with start and hold
        bif.seed0 = 4'd0; bif.seed1 = 4'd1; bif.num_terms = 8'd8; bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        tick();
        tick();
        check("clear/running_tv", 32'(bif.term_valid), 1);
        bif.clear = 1'b1;
        bif.start = 1'b1;
        bif.hold  = 1'b1;
        tick();
        check("clear/busy", 32'(bif.busy), 0);
        check("clear/tv",   32'(bif.term_valid), 0);
        check("clear/done", 32'(bif.done), 0);
        bif.clear = 1'b0;
        bif.start = 1'b0;
        bif.hold  = 1'b0;
        tick();
        check("clear/no_done", 32'(bif.done), 0);
        check("clear/stay_idle", 32'(bif.busy), 0);

        for (int r = 0; r < 25; r++) begin
            int s0, s1, nt;
            logic [63:0] hm;
            s0 = int'($urandom_range(0, 15));
            s1 = int'($urandom_range(0, 15));
            nt = int'($urandom_range(0, 20));
            hm = {$urandom, $urandom} & {$urandom, $urandom};
            run_seq($sformatf("rand%0d", r), s0, s1, nt, hm, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fibo_gen_param.md
FIBO_GEN_PARAM -- requirements
Module: fibo_gen_param

Interface
REQ-001 Parameter WIDTH, default 8, term width in bits (>=2).
REQ-002 Parameter CNT_W, default 8, width of term count and index.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-005 start  input  1  request new sequence; sampled only in IDLE.
REQ-006 clear  input  1  synchronous abort to IDLE.
REQ-007 hold  input  1  pause sequence generation while 1.
REQ-008 seed0  input  WIDTH  term 0 value, latched on accepted start.
REQ-009 seed1  input  WIDTH  term 1 value, latched on accepted start.
REQ-010 num_terms  input  CNT_W  number of terms to emit, latched on accepted start.
REQ-011 term  output  WIDTH  current emitted term, registered.
REQ-012 term_valid  output  1  term/term_index valid this cycle, registered.
REQ-013 term_index  output  CNT_W  index of emitted term, 0-based, registered.
REQ-014 busy  output  1  1 in RUN or DONE.
REQ-015 done  output  1  one-cycle pulse at sequence end (normal or overflow).
REQ-016 overflow  output  1  sticky: sequence stopped because next term exceeds WIDTH bits.

Function
REQ-017 FSM states IDLE, RUN, DONE; internal regs a, b (WIDTH), a_ok, b_ok, idx (CNT_W), n (CNT_W).
REQ-018 IDLE: start=1 and clear=0 -> a<=seed0, b<=seed1, a_ok<=1, b_ok<=1, idx<=0, n<=num_terms, overflow<=0; next state RUN if num_terms!=0, else DONE.
REQ-019 RUN, hold=0, a_ok=1: term<=a, term_index<=idx, term_valid<=1; if idx==n-1 -> DONE, else a<=b, b<=a+b (low WIDTH bits), a_ok<=b_ok, b_ok<=a_ok & b_ok & ~carry(a+b), idx<=idx+1.
REQ-020 RUN, hold=0, a_ok=0: no term emitted, term_valid<=0, overflow<=1, -> DONE.
REQ-021 RUN, hold=1: all internal regs frozen, term_valid<=0, term/term_index hold last value.
REQ-022 DONE: done=1 for exactly one cycle, term_valid=0, then -> IDLE unconditionally.
REQ-023 term_valid is 0 in every cycle not immediately following an emitting edge of REQ-019.
REQ-024 Latency: start sampled at edge k -> term 0 valid after edge k+1; with hold=0, term i valid after edge k+1+i; done high after edge k+1+n.
REQ-025 start ignored while busy=1; no queuing.
REQ-026 clear=1 in any state -> IDLE next edge, term_valid<=0, no done pulse, overflow unchanged; clear beats start and hold.
REQ-027 Addition is WIDTH+1 bit; emitted terms never wrap; a wrapped value is never presented with term_valid=1.
REQ-028 num_terms=0 -> no terms, done pulse one cycle after start sampled, overflow=0.
REQ-029 Arbitrary seeds supported (e.g. Lucas 2,1); seeds themselves always valid.

Reset
REQ-030 reset=0 -> state IDLE, a=0, b=1, a_ok=b_ok=1, idx=n=0, term=0, term_index=0, term_valid=0, busy=0, done=0, overflow=0, asynchronously.
REQ-031 Reset mid-RUN aborts immediately; no done pulse; first start after release behaves per REQ-018.

Verification
REQ-032 WIDTH=4, seeds 0,1, num_terms=8, hold=0 -> terms 0,1,1,2,3,5,8,13 on 8 consecutive cycles, indices 0..7, done one cycle later, overflow=0.
REQ-033 WIDTH=4, seeds 0,1, num_terms=12 -> terms 0..13 (8 terms), then overflow=1 and done pulse, term 21 never valid.
REQ-034 WIDTH=8, seeds 2,1, num_terms=5, hold=1 for 3 cycles after term 2 -> 2,1,3, three invalid cycles, 4,7, done.
REQ-035 num_terms=0 -> done pulse one cycle after start, term_valid never 1; start while busy ignored.
REQ-036 reset low after term 3 of REQ-032 -> all outputs at reset values immediately, no done; restart reproduces full sequence; clear mid-run -> IDLE, no done.
